// File: rtl/video_timing_pkg.sv
// Video timing constants and helpers.
// Shared by the timing generator and its sub-blocks.
package video_timing_pkg;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
    int   pclk_khz;
  } vt_mode_t;

  localparam int PIX_LAT_MAX = 7;

  localparam vt_mode_t VT_800X480_50 = '{
    h_active: 800, h_fp: 24, h_sync: 72, h_bp: 90,
    v_active: 480, v_fp: 5, v_sync: 7, v_bp: 12,
    hs_pol: 1'b0, vs_pol: 1'b0, pclk_khz: 25000
  };

  localparam vt_mode_t VT_800X480_60 = '{
    h_active: 800, h_fp: 40, h_sync: 48, h_bp: 40,
    v_active: 480, v_fp: 13, v_sync: 3, v_bp: 29,
    hs_pol: 1'b0, vs_pol: 1'b0, pclk_khz: 30000
  };

  localparam vt_mode_t VT_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0, pclk_khz: 25000
  };

  function automatic logic sync_inactive(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Width x depth shift register, flushed to zero on reset.
// Depth 0 degenerates to a plain wire.
module video_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (D == 0) begin : g_wire
    assign o_q = i_d;
  end else begin : g_pipe
    logic [W-1:0] r_q [D];

    // Shift one stage per clock; reset clears every stage.
    always_ff @(posedge Clock) begin
      if (!Reset) begin
        for (int k = 0; k < D; k++) r_q[k] <= '0;
      end else begin
        r_q[0] <= i_d;
        for (int k = 1; k < D; k++) r_q[k] <= r_q[k-1];
      end
    end

    assign o_q = r_q[D-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with scroll-wrapped pixel coordinates.
// Syncs and blanking are delayed to line up with returned pixel data.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VT_800X480_50.h_active,
  parameter int   H_FP     = VT_800X480_50.h_fp,
  parameter int   H_SYNC   = VT_800X480_50.h_sync,
  parameter int   H_BP     = VT_800X480_50.h_bp,
  parameter int   V_ACTIVE = VT_800X480_50.v_active,
  parameter int   V_FP     = VT_800X480_50.v_fp,
  parameter int   V_SYNC   = VT_800X480_50.v_sync,
  parameter int   V_BP     = VT_800X480_50.v_bp,
  parameter int   CW       = 11,
  parameter int   COLOR_W  = 8,
  parameter int   PIX_LAT  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [COLOR_W-1:0] Red,
  input  logic [COLOR_W-1:0] Green,
  input  logic [COLOR_W-1:0] Blue,
  input  logic [CW-1:0]      HScrollOffset,
  input  logic [CW-1:0]      VScrollOffset,
  output logic               H_Sync_out,
  output logic               V_Sync_out,
  output logic               VideoBlanking_L,
  output logic [COLOR_W-1:0] Red_out,
  output logic [COLOR_W-1:0] Green_out,
  output logic [COLOR_W-1:0] Blue_out,
  output logic [CW-1:0]      Column_out,
  output logic [CW-1:0]      Row_out,
  output logic               Frame_Start,
  output logic               Line_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DLY     = PIX_LAT + 1;

  if (PIX_LAT < 0 || PIX_LAT > PIX_LAT_MAX) begin : g_bad_lat
    $error("video_timing_gen: PIX_LAT must be 0..7");
  end

  if (longint'(H_TOTAL - 1) >= (longint'(1) << CW) ||
      longint'(V_TOTAL - 1) >= (longint'(1) << CW)) begin : g_bad_cw
    $error("video_timing_gen: CW too narrow for totals");
  end

  localparam logic [CW-1:0] HT_M1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT_M1 = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   HA    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   VA    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   HS_B  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_E  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_B  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_E  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_hcnt, r_vcnt;
  logic [CW-1:0] r_hoff, r_voff;
  logic [CW-1:0] r_col, r_row;

  logic          w_hend, w_vend;
  logic          w_hact, w_vact;
  logic          w_hs, w_vs, w_de, w_fs, w_ls;
  logic [CW-1:0] w_hin, w_vin;
  logic [CW-1:0] w_hoff, w_voff;
  logic [CW:0]   w_hsum, w_vsum;
  logic [CW-1:0] w_hwrap, w_vwrap;
  logic [4:0]    w_req, w_req_d;

  // Raster position decode, scroll clamp/shadow select and coordinate wrap.
  always_comb begin
    w_hend = (r_hcnt == HT_M1);
    w_vend = (r_vcnt == VT_M1);
    w_hact = ({1'b0, r_hcnt} < HA);
    w_vact = ({1'b0, r_vcnt} < VA);
    w_hs   = ({1'b0, r_hcnt} >= HS_B) &&
             ({1'b0, r_hcnt} <  HS_E);
    w_vs   = ({1'b0, r_vcnt} >= VS_B) &&
             ({1'b0, r_vcnt} <  VS_E);
    w_de   = w_hact && w_vact;
    w_fs   = (r_hcnt == '0) && (r_vcnt == '0);
    w_ls   = (r_hcnt == '0);
    w_hin  = ({1'b0, HScrollOffset} >= HA) ?
             '0 : HScrollOffset;
    w_vin  = ({1'b0, VScrollOffset} >= VA) ?
             '0 : VScrollOffset;
    w_hoff = (!Reset || w_fs) ? w_hin : r_hoff;
    w_voff = (!Reset || w_fs) ? w_vin : r_voff;
    w_hsum = {1'b0, r_hcnt} + {1'b0, w_hoff};
    w_vsum = {1'b0, r_vcnt} + {1'b0, w_voff};
    w_hwrap = (w_hsum >= HA) ?
              CW'(w_hsum - HA) : CW'(w_hsum);
    w_vwrap = (w_vsum >= VA) ?
              CW'(w_vsum - VA) : CW'(w_vsum);
    w_req  = {w_hs, w_vs, w_de, w_fs, w_ls};
  end

  // Horizontal/vertical counters; vertical steps on the horizontal wrap.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_hend) begin
      r_hcnt <= '0;
      r_vcnt <= w_vend ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Scroll shadows (frame-locked) and registered pixel-source coordinate.
  always_ff @(posedge Clock) begin
    r_hoff <= w_hoff;
    r_voff <= w_voff;
    if (!Reset) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_hact ? w_hwrap : '0;
      r_row <= w_vact ? w_vwrap : '0;
    end
  end

  video_delay_line #(
    .W (5),
    .D (DLY)
  ) u_req_dly (
    .Clock (Clock),
    .Reset (Reset),
    .i_d   (w_req),
    .o_q   (w_req_d)
  );

  assign Column_out      = r_col;
  assign Row_out         = r_row;
  assign H_Sync_out      = w_req_d[4] ? HS_POL : sync_inactive(HS_POL);
  assign V_Sync_out      = w_req_d[3] ? VS_POL : sync_inactive(VS_POL);
  assign VideoBlanking_L = w_req_d[2];
  assign Frame_Start     = w_req_d[1];
  assign Line_Start      = w_req_d[0];
  assign Red_out         = Red   & {COLOR_W{w_req_d[2]}};
  assign Green_out       = Green & {COLOR_W{w_req_d[2]}};
  assign Blue_out        = Blue  & {COLOR_W{w_req_d[2]}};

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (latency 2, 0, 7/inverted syncs)
// against a time-indexed raster model plus literal expectations.
module tb_video_timing_gen;

  localparam int NC = 3;
  localparam logic [8:0] LATV = {3'd7, 3'd0, 3'd2};
  localparam logic [2:0] POLV = 3'b100;

  int lat [NC] = '{2, 0, 7};
  bit pol [NC] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [10:0] hscr = '0;
  logic [10:0] vscr = '0;
  logic [7:0]  blu_i = 8'h5A;
  logic [7:0]  red_i [NC];
  logic [7:0]  grn_i [NC];
  logic        hs_o [NC], vs_o [NC], bl_o [NC];
  logic        fs_o [NC], ls_o [NC];
  logic [7:0]  r_o [NC], g_o [NC], b_o [NC];
  logic [10:0] col_o [NC], row_o [NC];

  for (genvar k = 0; k < NC; k++) begin : g_dut
    video_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .CW (11), .COLOR_W (8),
      .PIX_LAT (int'(LATV[3*k +: 3])),
      .HS_POL (POLV[k]), .VS_POL (POLV[k])
    ) u_dut (
      .Clock           (clk),
      .Reset           (rst_n),
      .Red             (red_i[k]),
      .Green           (grn_i[k]),
      .Blue            (blu_i),
      .HScrollOffset   (hscr),
      .VScrollOffset   (vscr),
      .H_Sync_out      (hs_o[k]),
      .V_Sync_out      (vs_o[k]),
      .VideoBlanking_L (bl_o[k]),
      .Red_out         (r_o[k]),
      .Green_out       (g_o[k]),
      .Blue_out        (b_o[k]),
      .Column_out      (col_o[k]),
      .Row_out         (row_o[k]),
      .Frame_Start     (fs_o[k]),
      .Line_Start      (ls_o[k])
    );
  end

  // Model: request n is fully determined by clocks since reset release.
  typedef struct {
    bit hs, vs, de, fs, ls;
    int col, row;
  } req_t;

  req_t hist [8];
  int   t, hoff, voff, col_e, row_e;

  function automatic int clampv(int x, int act);
    return (x >= act) ? 0 : x;
  endfunction

  initial begin
    req_t r;
    int h, v;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0;
        hoff = clampv(int'(hscr), 8);
        voff = clampv(int'(vscr), 4);
        col_e = 0;
        row_e = 0;
        for (int i = 0; i < 8; i++) hist[i] = '{default: 0};
      end else begin
        h = t % 16;
        v = (t / 16) % 8;
        if (h == 0 && v == 0) begin
          hoff = clampv(int'(hscr), 8);
          voff = clampv(int'(vscr), 4);
        end
        r.hs = (h >= 10 && h < 13);
        r.vs = (v >= 5 && v < 7);
        r.de = (h < 8 && v < 4);
        r.fs = (h == 0 && v == 0);
        r.ls = (h == 0);
        col_e = (h < 8) ? (h + hoff) % 8 : 0;
        row_e = (v < 4) ? (v + voff) % 4 : 0;
        r.col = col_e;
        r.row = row_e;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = r;
        t++;
      end
    end
  end

  // Pixel source: returns each instance's own coordinate after its latency.
  logic [7:0] chist [NC][8];
  logic [7:0] rhist [NC][8];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NC; k++) begin
        for (int j = 7; j > 0; j--) begin
          chist[k][j] = chist[k][j-1];
          rhist[k][j] = rhist[k][j-1];
        end
        chist[k][0] = col_o[k][7:0];
        rhist[k][0] = row_o[k][7:0];
        red_i[k] = chist[k][lat[k]];
        grn_i[k] = rhist[k][lat[k]];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string nm, int k, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    req_t e;
    for (int k = 0; k < NC; k++) begin
      e = hist[lat[k]];
      check("hsync", k, int'(hs_o[k]), int'(e.hs ? pol[k] : !pol[k]));
      check("vsync", k, int'(vs_o[k]), int'(e.vs ? pol[k] : !pol[k]));
      check("blank", k, int'(bl_o[k]), int'(e.de));
      check("fstart", k, int'(fs_o[k]), int'(e.fs));
      check("lstart", k, int'(ls_o[k]), int'(e.ls));
      check("column", k, int'(col_o[k]), col_e);
      check("row", k, int'(row_o[k]), row_e);
      check("red", k, int'(r_o[k]), e.de ? e.col : 0);
      check("green", k, int'(g_o[k]), e.de ? e.row : 0);
      check("blue", k, int'(b_o[k]), e.de ? 'h5A : 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fs_o[0] && n < 200);
    if (!fs_o[0]) check("wait_fs", 0, int'(fs_o[0]), 1);
  endtask

  int cr [32];
  int cg [32];

  task automatic cap_frame(input int chg, input logic [10:0] chgv);
    int cnt, j;
    wait_fs();
    cnt = 0;
    j = 0;
    while (cnt < 32 && j < 140) begin
      if (bl_o[0]) begin
        cr[cnt] = int'(r_o[0]);
        cg[cnt] = int'(g_o[0]);
        cnt++;
      end
      if (j == chg) hscr = chgv;
      tick();
      j++;
    end
    check("cap_count", 0, cnt, 32);
  endtask

  initial begin
    int first [NC];
    int hl, vl, bh, fc, hp, lastfs, per, n;

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_hs", 0, int'(hs_o[0]), 1);
    check("rst_hs", 2, int'(hs_o[2]), 0);
    check("rst_blank", 0, int'(bl_o[0]), 0);
    check("rst_col", 0, int'(col_o[0]), 0);

    rst_n = 1'b1;
    first = '{-1, -1, -1};
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int k = 0; k < NC; k++)
        if (fs_o[k] && first[k] < 0) first[k] = i;
    end
    check("fs_latency", 0, first[0], 3);
    check("fs_latency", 1, first[1], 1);
    check("fs_latency", 2, first[2], 8);

    hl = 0; vl = 0; bh = 0; fc = 0; hp = 0;
    lastfs = -1; per = 0;
    for (int i = 0; i < 384; i++) begin
      tick();
      if (!hs_o[0]) hl++;
      if (!vs_o[0]) vl++;
      if (bl_o[0]) bh++;
      if (hs_o[2]) hp++;
      if (fs_o[0]) begin
        if (lastfs >= 0) per = i - lastfs;
        lastfs = i;
        fc++;
      end
    end
    check("hs_low_clks", 0, hl, 72);
    check("vs_low_clks", 0, vl, 96);
    check("de_clks", 0, bh, 96);
    check("fs_count", 0, fc, 3);
    check("fs_period", 0, per, 128);
    check("hs_high_inv", 2, hp, 72);

    cap_frame(-1, '0);
    for (int i = 0; i < 8; i++) check("ramp", i, cr[i], i);
    check("ramp_row", 0, cg[0], 0);
    check("ramp_row", 3, cg[24], 3);

    hscr = 11'd5;
    vscr = 11'd3;
    cap_frame(-1, '0);
    check("scr5_col", 0, cr[0], 5);
    check("scr5_col", 2, cr[2], 7);
    check("scr5_col", 3, cr[3], 0);
    check("scr5_col", 7, cr[7], 4);
    check("scr3_row", 0, cg[0], 3);
    check("scr3_row", 1, cg[8], 0);
    check("scr3_row", 2, cg[16], 1);
    check("scr3_row", 3, cg[24], 2);

    hscr = 11'd2;
    cap_frame(16, 11'd6);
    check("scr2_hold", 0, cr[0], 2);
    check("scr2_hold", 24, cr[24], 2);
    check("scr2_hold", 31, cr[31], 1);
    cap_frame(-1, '0);
    check("scr6_next", 0, cr[0], 6);
    hscr = 11'd9;
    cap_frame(-1, '0);
    check("scr9_clamp", 0, cr[0], 0);
    check("scr9_clamp", 3, cr[3], 3);

    wait_fs();
    repeat (87) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_hs", 0, int'(hs_o[0]), 1);
    check("mid_rst_vs", 0, int'(vs_o[0]), 1);
    check("mid_rst_blank", 0, int'(bl_o[0]), 0);
    check("mid_rst_fs", 0, int'(fs_o[0]), 0);
    check("mid_rst_ls", 0, int'(ls_o[0]), 0);
    check("mid_rst_col", 0, int'(col_o[0]), 0);
    check("mid_rst_row", 0, int'(row_o[0]), 0);
    check("mid_rst_red", 0, int'(r_o[0]), 0);
    check("mid_rst_hs", 2, int'(hs_o[2]), 0);
    check("mid_rst_vs", 2, int'(vs_o[2]), 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!fs_o[0] && n < 20);
    check("rel_fs_lat", 0, n, 3);

    repeat (140) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
